// File: rtl/flash_cal_sequencer_pkg.sv
// flash_cal_pkg: shared types and defaults for the flash ADC calibration sequencer.
//   state_t   - sequencer FSM states
//   phase_t   - calibration phase (MEAS, TRIM, VERIFY)
//   *_DEF     - default sizes for the comparator bank, DAC and trim fields
//   trim_lsb  - low bit of comparator idx inside a packed trim bus
`timescale 1ns/1ps
package flash_cal_pkg;

    localparam int unsigned N_CMP_DEF    = 32;
    localparam int unsigned DAC_BITS_DEF = 16;
    localparam int unsigned TRIM_W_DEF   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAR_TRY,
        S_SAR_WAIT,
        S_TRIM_REF,
        S_TRIM_WAIT,
        S_TRIM_STEP,
        S_NEXT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MEAS,
        TRIM,
        VERIFY
    } phase_t;

    function automatic int unsigned trim_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/flash_cal_sequencer_if.sv
// flash_cal_sequencer_if: control, comparator and register-file signals of the
// calibration sequencer.
//   start/abort     host requests
//   q               comparator outputs
//   dac_ctl         reference DAC code
//   cal_bot/cal_top bottom trims / active-low top trims
//   cmp_idx, rdy, busy, done, sat   progress and status
//   rd_idx, rd_bank, rd_thr         threshold register-file read port
// slave = sequencer side, master = host / analog side.
`timescale 1ns/1ps
interface flash_cal_sequencer_if
    import flash_cal_pkg::*;
#(
    parameter int unsigned N_CMP    = N_CMP_DEF,
    parameter int unsigned DAC_BITS = DAC_BITS_DEF,
    parameter int unsigned TRIM_W   = TRIM_W_DEF
);
    logic                      start;
    logic                      abort;
    logic [N_CMP-1:0]          q;
    logic [DAC_BITS-1:0]       dac_ctl;
    logic [N_CMP*TRIM_W-1:0]   cal_bot;
    logic [N_CMP*TRIM_W-1:0]   cal_top;
    logic [4:0]                cmp_idx;
    logic                      rdy;
    logic                      busy;
    logic                      done;
    logic [N_CMP-1:0]          sat;
    logic [4:0]                rd_idx;
    logic                      rd_bank;
    logic [DAC_BITS-1:0]       rd_thr;

    modport slave (
        input  start, abort, q, rd_idx, rd_bank,
        output dac_ctl, cal_bot, cal_top, cmp_idx, rdy, busy, done, sat, rd_thr
    );

    modport master (
        output start, abort, q, rd_idx, rd_bank,
        input  dac_ctl, cal_bot, cal_top, cmp_idx, rdy, busy, done, sat, rd_thr
    );
endinterface

// File: rtl/flash_cal_sequencer_sar_step.sv
// flash_sar_step: successive-approximation engine for one comparator.
//   init     load first trial (MSB set, all lower bits clear)
//   decide   apply the sampled comparator bit to the current trial bit and
//            advance to the next lower bit
//   q_s      sampled comparator output (1 = DAC at or above threshold)
//   code     current trial / final result code (registered)
//   code_nxt code after this cycle's init/decide; used to preload the DAC register
//   last     current trial is bit 0
`timescale 1ns/1ps
module flash_sar_step #(
    parameter int unsigned DAC_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                decide,
    input  logic                q_s,
    output logic [DAC_BITS-1:0] code,
    output logic [DAC_BITS-1:0] code_nxt,
    output logic                last
);
    localparam int unsigned BW = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;

    logic [DAC_BITS-1:0] code_q;
    logic [BW-1:0]       bit_q;
    logic [BW-1:0]       bit_nxt;

    always_comb begin
        code_nxt = code_q;
        bit_nxt  = bit_q;
        if (init) begin
            code_nxt               = '0;
            code_nxt[DAC_BITS-1]   = 1'b1;
            bit_nxt                = BW'(DAC_BITS - 1);
        end else if (decide) begin
            // q=1 means the trial overshot: drop the bit
            if (q_s) begin
                code_nxt[bit_q] = 1'b0;
            end
            if (bit_q != '0) begin
                bit_nxt           = bit_q - 1'b1;
                code_nxt[bit_nxt] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            bit_q  <= '0;
        end else begin
            code_q <= code_nxt;
            bit_q  <= bit_nxt;
        end
    end

    assign code = code_q;
    assign last = (bit_q == '0);

endmodule

// File: rtl/flash_cal_sequencer.sv
// flash_cal_sequencer: calibration sequencer for the flash ADC comparator bank.
// For each comparator it runs a SAR threshold search (MEAS, bank 0), a trim
// search toward a per-comparator target code (TRIM), then a SAR with trims
// applied (VERIFY, bank 1).
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus.slave   start/abort/q in; dac_ctl, trims, cmp_idx, rdy, busy, done,
//               sat out; rd_idx/rd_bank in and rd_thr out (combinational read)
`timescale 1ns/1ps
module flash_cal_sequencer
    import flash_cal_pkg::*;
#(
    parameter int unsigned N_CMP    = N_CMP_DEF,
    parameter int unsigned DAC_BITS = DAC_BITS_DEF,
    parameter int unsigned TRIM_W   = TRIM_W_DEF,
    parameter int unsigned SETTLE   = 1,
    parameter int unsigned TGT_BASE = 13033,
    parameter int unsigned TGT_STEP = 1117
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flash_cal_sequencer_if.slave  bus
);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned TW = DAC_BITS + 5;
    localparam logic [TRIM_W-1:0] TMAX = '1;

    state_t                  state;
    state_t                  state_nxt;
    phase_t                  phase;
    phase_t                  nxt_phase;
    logic [4:0]              cmp_idx;
    logic [4:0]              nxt_idx;
    logic [DAC_BITS-1:0]     dac_r;
    logic [N_CMP*TRIM_W-1:0] bot_r;
    logic [N_CMP*TRIM_W-1:0] top_r;
    logic [N_CMP-1:0]        sat_r;
    logic                    done_r;
    logic [DAC_BITS-1:0]     thr0 [N_CMP];
    logic [DAC_BITS-1:0]     thr1 [N_CMP];
    logic [CW-1:0]           cnt;
    logic [TRIM_W-1:0]       ctr;
    logic                    p0;

    logic                    busy;
    logic                    settle_hit;
    logic                    q_s;
    logic                    last_cmp;
    logic                    sar_init;
    logic                    sar_decide;
    logic                    sar_last;
    logic [DAC_BITS-1:0]     sar_code;
    logic [DAC_BITS-1:0]     sar_code_nxt;
    int unsigned             lsb;

    // Trim target for comparator idx, saturated to the DAC range.
    function automatic logic [DAC_BITS-1:0] tgt_of(input logic [4:0] idx);
        logic [TW-1:0] t;
        t = TW'(TGT_BASE) + TW'(idx) * TW'(TGT_STEP);
        if (|t[TW-1:DAC_BITS]) begin
            return '1;
        end
        return t[DAC_BITS-1:0];
    endfunction

    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign settle_hit = (cnt == CW'(SETTLE - 1));
    assign q_s        = bus.q[cmp_idx];
    assign last_cmp   = (cmp_idx == 5'(N_CMP - 1));
    assign lsb        = trim_lsb(32'(cmp_idx), TRIM_W);

    flash_sar_step #(.DAC_BITS(DAC_BITS)) u_sar (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (sar_init),
        .decide   (sar_decide),
        .q_s      (q_s),
        .code     (sar_code),
        .code_nxt (sar_code_nxt),
        .last     (sar_last)
    );

    always_comb begin
        nxt_idx   = cmp_idx + 5'd1;
        nxt_phase = phase;
        if (last_cmp) begin
            nxt_idx   = '0;
            nxt_phase = (phase == MEAS) ? TRIM : VERIFY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each trial occupies SETTLE cycles: the first in *_TRY/*_REF/*_STEP, the
    // rest in the matching wait state; q is sampled only on the settle_hit cycle.
    always_comb begin
        state_nxt  = state;
        sar_init   = 1'b0;
        sar_decide = 1'b0;
        if (busy && bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_nxt = S_SAR_TRY;
                        sar_init  = 1'b1;
                    end
                end
                S_SAR_TRY, S_SAR_WAIT: begin
                    if (settle_hit) begin
                        sar_decide = 1'b1;
                        state_nxt  = sar_last ? S_NEXT : S_SAR_TRY;
                    end else begin
                        state_nxt = S_SAR_WAIT;
                    end
                end
                S_TRIM_REF: begin
                    if (settle_hit) begin
                        state_nxt = S_TRIM_STEP;
                    end
                end
                S_TRIM_STEP, S_TRIM_WAIT: begin
                    if (settle_hit) begin
                        state_nxt = ((q_s != p0) || (ctr == TMAX)) ? S_NEXT : S_TRIM_STEP;
                    end else begin
                        state_nxt = S_TRIM_WAIT;
                    end
                end
                S_NEXT: begin
                    if (last_cmp && (phase == VERIFY)) begin
                        state_nxt = S_DONE;
                    end else if (nxt_phase == TRIM) begin
                        state_nxt = S_TRIM_REF;
                    end else begin
                        state_nxt = S_SAR_TRY;
                        sar_init  = 1'b1;
                    end
                end
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= MEAS;
            cmp_idx <= '0;
            dac_r   <= '0;
            bot_r   <= '0;
            top_r   <= '0;
            sat_r   <= '0;
            done_r  <= 1'b0;
            cnt     <= '0;
            ctr     <= '0;
            p0      <= 1'b0;
            for (int unsigned i = 0; i < N_CMP; i++) begin
                thr0[i] <= '0;
                thr1[i] <= '0;
            end
        end else if (busy && bus.abort) begin
            dac_r <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        top_r   <= '0;
                        bot_r   <= '0;
                        sat_r   <= '0;
                        done_r  <= 1'b0;
                        phase   <= MEAS;
                        cmp_idx <= '0;
                        cnt     <= '0;
                        dac_r   <= sar_code_nxt;
                    end
                end
                S_SAR_TRY, S_SAR_WAIT: begin
                    if (settle_hit) begin
                        cnt <= '0;
                        if (!sar_last) begin
                            dac_r <= sar_code_nxt;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TRIM_REF: begin
                    if (settle_hit) begin
                        // p0 picks the side that moves the threshold toward the target
                        cnt <= '0;
                        p0  <= q_s;
                        ctr <= TRIM_W'(1);
                        if (q_s) begin
                            top_r[lsb +: TRIM_W] <= TRIM_W'(1);
                        end else begin
                            bot_r[lsb +: TRIM_W] <= TRIM_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TRIM_STEP, S_TRIM_WAIT: begin
                    if (settle_hit) begin
                        cnt <= '0;
                        if (q_s == p0) begin
                            if (ctr == TMAX) begin
                                sat_r[cmp_idx] <= 1'b1;
                            end else begin
                                ctr <= ctr + 1'b1;
                                if (p0) begin
                                    top_r[lsb +: TRIM_W] <= ctr + 1'b1;
                                end else begin
                                    bot_r[lsb +: TRIM_W] <= ctr + 1'b1;
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    cnt <= '0;
                    if (phase == MEAS) begin
                        thr0[cmp_idx] <= sar_code;
                    end else if (phase == VERIFY) begin
                        thr1[cmp_idx] <= sar_code;
                    end
                    if (last_cmp && (phase == VERIFY)) begin
                        dac_r  <= '0;
                        done_r <= 1'b1;
                    end else begin
                        cmp_idx <= nxt_idx;
                        phase   <= nxt_phase;
                        dac_r   <= (nxt_phase == TRIM) ? tgt_of(nxt_idx) : sar_code_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dac_ctl = dac_r;
    assign bus.cal_bot = bot_r;
    assign bus.cal_top = ~top_r;
    assign bus.cmp_idx = cmp_idx;
    assign bus.rdy     = (state == S_NEXT);
    assign bus.busy    = busy;
    assign bus.done    = done_r;
    assign bus.sat     = sat_r;
    assign bus.rd_thr  = bus.rd_bank ? thr1[bus.rd_idx] : thr0[bus.rd_idx];

endmodule

// File: tb/tb_flash_cal_sequencer.sv
// Testbench for flash_cal_sequencer: behavioural comparator bank, a scoreboard
// of expected (phase, index, trim) per rdy pulse, and a table of expected
// register-file contents read back after each run.
`timescale 1ns/1ps
module tb_flash_cal_sequencer;
    import flash_cal_pkg::*;

    localparam int N        = 32;
    localparam int DB       = 16;
    localparam int TW       = 4;
    localparam int TGT_BASE = 13033;
    localparam int TGT_STEP = 1117;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flash_cal_sequencer_if #(.N_CMP(N), .DAC_BITS(DB), .TRIM_W(TW)) bus ();

    flash_cal_sequencer #(
        .N_CMP(N), .DAC_BITS(DB), .TRIM_W(TW), .SETTLE(1),
        .TGT_BASE(TGT_BASE), .TGT_STEP(TGT_STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [1:0] ph; int idx; int tp; int bt; } sb_t;
    typedef struct { logic bank; logic [4:0] idx; int exp; } rv_t;

    int   thr_t [N];
    int   e_thr0 [N], e_thr1 [N], e_top [N], e_bot [N];
    logic [N-1:0] e_sat;
    int   e_cycles;
    sb_t  sbq [$];
    rv_t  rv [2*N];
    int   n_chk = 0, n_pass = 0, n_rdy = 0;

    function automatic int tgt_of(input int i);
        int t;
        t = TGT_BASE + i * TGT_STEP;
        return (t > 65535) ? 65535 : t;
    endfunction

    function automatic int sar_of(input int teff);
        if (teff <= 0) return 0;
        if (teff > 65535) return 65535;
        return teff - 1;
    endfunction

    function automatic int teff_of(input int t, input logic [TW-1:0] tp, input logic [TW-1:0] bt);
        return t + 300 * int'(tp) - 300 * int'(bt);
    endfunction

    function automatic logic [TW-1:0] top_of(input int i);
        logic [TW-1:0] s;
        s = bus.cal_top[i*TW +: TW];
        return ~s;
    endfunction

    function automatic logic [TW-1:0] bot_of(input int i);
        return bus.cal_bot[i*TW +: TW];
    endfunction

    // comparator bank: q[i] = dac_ctl >= T_i + 300*top_i - 300*bot_i
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.q[i] = int'(bus.dac_ctl) >= teff_of(thr_t[i], ~bus.cal_top[i*TW +: TW], bus.cal_bot[i*TW +: TW]);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic build_model();
        int tg, c, tp, bt;
        bit p0, q;
        e_cycles = 64 * 17;
        e_sat = '0;
        for (int i = 0; i < N; i++) begin
            tg = tgt_of(i);
            e_thr0[i] = sar_of(thr_t[i]);
            p0 = (tg >= thr_t[i]);
            tp = 0; bt = 0;
            for (c = 1; c <= 15; c++) begin
                if (p0) tp = c; else bt = c;
                q = (tg >= thr_t[i] + 300 * tp - 300 * bt);
                if (q != p0) break;
            end
            if (c > 15) begin
                c = 15;
                e_sat[i] = 1'b1;
            end
            e_top[i] = tp;
            e_bot[i] = bt;
            e_thr1[i] = sar_of(thr_t[i] + 300 * tp - 300 * bt);
            e_cycles += 2 + c;
        end
        sbq.delete();
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < N; i++) begin
                sbq.push_back('{ph: 2'(ph), idx: i, tp: e_top[i], bt: e_bot[i]});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rdy) begin
            sb_t e;
            n_rdy++;
            if (sbq.size() == 0) begin
                chk("rdy_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("sb_idx_ph%0d_%0d", e.ph, e.idx), bus.cmp_idx, e.idx);
                if (e.ph == 2'd1) begin
                    chk($sformatf("sb_top_%0d", e.idx), top_of(e.idx), e.tp);
                    chk($sformatf("sb_bot_%0d", e.idx), bot_of(e.idx), e.bt);
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        n_rdy = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_full(input bit mid_start);
        int cyc;
        build_model();
        do_start();
        chk("run_busy", bus.busy, 1);
        chk("run_trims_cleared", (&bus.cal_top) && !(|bus.cal_bot), 1);
        chk("run_done_cleared", bus.done, 0);
        cyc = 0;
        while (!bus.done && cyc < 6000) begin
            if (mid_start && cyc == 300) bus.start = 1'b1;
            if (mid_start && cyc == 301) bus.start = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("run_done", bus.done, 1);
        chk("run_cycles", cyc, e_cycles);
        chk("done_busy", bus.busy, 0);
        chk("done_dac", bus.dac_ctl, 0);
        chk("sb_empty", sbq.size(), 0);
        chk("sat_vec", bus.sat, e_sat);
        for (int i = 0; i < N; i++) begin
            rv[i]     = '{bank: 1'b0, idx: 5'(i), exp: e_thr0[i]};
            rv[N + i] = '{bank: 1'b1, idx: 5'(i), exp: e_thr1[i]};
        end
        for (int k = 0; k < 2 * N; k++) begin
            bus.rd_bank = rv[k].bank;
            bus.rd_idx  = rv[k].idx;
            #1;
            chk($sformatf("thr%0d_%0d", rv[k].bank, rv[k].idx), bus.rd_thr, rv[k].exp);
        end
        @(negedge clk);
        chk("idle_done_level", bus.done, 1);
        chk("idle_busy", bus.busy, 0);
    endtask

    task automatic table_a();
        for (int i = 0; i < N; i++) thr_t[i] = tgt_of(i) + ((i % 7) - 3) * 350;
        thr_t[0] = 0;
        thr_t[1] = 70000;
        thr_t[3] = tgt_of(3) + 700;
        thr_t[5] = tgt_of(5) - 1000;
        thr_t[7] = tgt_of(7) - 10000;
    endtask

    task automatic wait_rdy(input int target);
        int n;
        n = 0;
        while (n_rdy < target && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("reach_rdy_%0d", target), n_rdy, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int quiet;
        logic [TW-1:0] s;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rd_idx = '0;
        bus.rd_bank = 1'b0;
        for (int i = 0; i < N; i++) thr_t[i] = 1000 * i + 500;

        // reset and idle
        #1;
        chk("rst_dac", bus.dac_ctl, 0);
        chk("rst_cal_top", &bus.cal_top, 1);
        chk("rst_cal_bot", |bus.cal_bot, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sat", bus.sat, 0);
        chk("rst_idx", bus.cmp_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy || bus.rdy || bus.dac_ctl != 0) quiet++;
        end
        chk("idle_quiet", quiet, 0);

        // ideal-SAR run, with a start pulse while busy that must be ignored
        run_full(1'b1);

        // abort during TRIM of comparator 10
        table_a();
        build_model();
        do_start();
        wait_rdy(42);
        @(negedge clk);
        chk("abort_idx", bus.cmp_idx, 10);
        chk("abort_busy_pre", bus.busy, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_dac", bus.dac_ctl, 0);
        chk("abort_done", bus.done, 0);
        @(negedge clk);
        bus.abort = 1'b0;
        sbq.delete();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("abort_keep_top_%0d", i), top_of(i), e_top[i]);
            chk($sformatf("abort_keep_bot_%0d", i), bot_of(i), e_bot[i]);
        end
        chk("abort_keep_sat", bus.sat[9:0], e_sat[9:0]);
        bus.rd_bank = 1'b0;
        bus.rd_idx = 5'd31;
        #1;
        chk("abort_keep_thr0_31", bus.rd_thr, e_thr0[31]);
        // start and abort together in IDLE: abort wins
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("start_abort_busy", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // full run with trims in reach, both trim sides and saturation
        run_full(1'b0);
        s = bus.cal_top[5*TW +: TW];
        chk("cal_top5_raw", s, 4'b1011);
        chk("bot5", bot_of(5), 0);
        chk("top7", top_of(7), 15);
        chk("sat7", bus.sat[7], 1);
        chk("bot3", bot_of(3), 3);
        bus.rd_bank = 1'b1;
        bus.rd_idx = 5'd5;
        #1;
        chk("thr1_5_tgt199", bus.rd_thr, tgt_of(5) + 199);

        // reset in the middle of VERIFY
        build_model();
        do_start();
        wait_rdy(69);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_dac", bus.dac_ctl, 0);
        chk("mrst_cal_top", &bus.cal_top, 1);
        chk("mrst_cal_bot", |bus.cal_bot, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_sat", bus.sat, 0);
        chk("mrst_idx", bus.cmp_idx, 0);
        chk("mrst_rdy", bus.rdy, 0);
        bus.rd_bank = 1'b0;
        bus.rd_idx = 5'd2;
        #1;
        chk("mrst_thr0", bus.rd_thr, 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_idle_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
